// File: rtl/dbus_pkg.sv
// Shared constants and types for the DBUS memory responder and its console FIFO.
package dbus_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0001_0000;
  localparam int          STAT_NOT_FULL    = 0;
  localparam int          STAT_EMPTY       = 1;
  localparam int          BYTE_W           = 8;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE
  } req_e;

endpackage

// File: rtl/dbus_mem_responder_console_fifo.sv
// Console character FIFO: push with full back-pressure, valid/ready drain from a registered head.
module console_fifo #(
  parameter int FIFO_AW = 3,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign valid_o = ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = valid_o & ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// DBUS responder: byte-lane word RAM with wait states plus a console register feeding a FIFO.
// Define DBUS_RESP_BUSERR_EN to add sticky unmapped-access error capture (oBusErr/oBusErrAddr).
module dbus_mem_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_AW       = 10,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iDbusAddr,
  input  logic        iDbusWe,
  input  logic        iDbusRead,
  input  logic [31:0] iDbusData,
  input  logic [3:0]  iDbusByteEn,
  output logic [31:0] oDbusData,
  output logic        oDbusWait,
  output logic        oConsoleValid,
  output logic [7:0]  oConsoleData,
  input  logic        iConsoleReady
`ifdef DBUS_RESP_BUSERR_EN
  ,
  output logic        oBusErr,
  output logic [31:0] oBusErrAddr
`endif
);

  localparam int         WORDS = 1 << MEM_AW;
  localparam logic [4:0] S_WR  = 5'(WAIT_CYCLES);
  localparam logic [4:0] S_RD  = 5'(WAIT_CYCLES + 1);

  req_e              req_type;
  logic              req, is_wr, is_rd;
  logic              in_range, con_sel, ram_sel;
  logic [4:0]        s_lim, cnt_q, cnt_d;
  logic              con_block, done;
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       mem_q [WORDS];
  logic [31:0]       rdata_q;
  logic [31:0]       status;
  logic              fifo_full, fifo_empty, fifo_push;
  logic              unused_addr_lsb;

  // Write wins when both strobes are high.
  always_comb begin
    req_type = REQ_NONE;
    if (iDbusWe)        req_type = REQ_WRITE;
    else if (iDbusRead) req_type = REQ_READ;
  end

  assign req      = (req_type != REQ_NONE);
  assign is_wr    = (req_type == REQ_WRITE);
  assign is_rd    = (req_type == REQ_READ);
  assign in_range = (iDbusAddr[31:MEM_AW+2] == '0);
  assign con_sel  = ({iDbusAddr[31:2], 2'b00} == CONSOLE_ADDR);
  assign ram_sel  = in_range & ~con_sel;
  assign word_idx = iDbusAddr[MEM_AW+1:2];
  assign unused_addr_lsb = ^iDbusAddr[1:0];

  assign s_lim     = is_wr ? S_WR : S_RD;
  assign con_block = is_wr & con_sel & fifo_full;
  assign oDbusWait = req & ((cnt_q != s_lim) | con_block);
  assign done      = req & ~oDbusWait;

  // Counter saturates at the limit while a console write waits for a free slot.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || done)        cnt_d = '0;
    else if (cnt_q != s_lim) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (done && is_wr && ram_sel && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (iDbusByteEn[k]) mem_q[word_idx][k*BYTE_W +: BYTE_W] <= iDbusData[k*BYTE_W +: BYTE_W];
      end
    end
    rdata_q <= mem_q[word_idx];
  end

  always_comb begin
    status                = '0;
    status[STAT_NOT_FULL] = ~fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
  end

  always_comb begin
    oDbusData = '0;
    if (done && is_rd) begin
      if (con_sel)      oDbusData = status;
      else if (ram_sel) oDbusData = rdata_q;
    end
  end

  assign fifo_push = done & is_wr & con_sel & iDbusByteEn[0] & ~rst;

  console_fifo #(
    .FIFO_AW (FIFO_AW),
    .WIDTH   (BYTE_W)
  ) u_console_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (iDbusData[7:0]),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (oConsoleValid),
    .data_o      (oConsoleData),
    .ready_i     (iConsoleReady)
  );

`ifdef DBUS_RESP_BUSERR_EN
  logic        berr_q;
  logic [31:0] berr_addr_q;
  logic        unmapped;

  assign unmapped    = ~in_range & ~con_sel;
  assign oBusErr     = berr_q;
  assign oBusErrAddr = berr_addr_q;

  // Only the first error address is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      berr_q      <= 1'b0;
      berr_addr_q <= '0;
    end else if (done && unmapped && !berr_q) begin
      berr_q      <= 1'b1;
      berr_addr_q <= iDbusAddr;
    end
  end
`endif

endmodule
